// File: rtl/vote_tally_if.sv
// Signal bundle between the vote qualify/display stages and vote_tally.
// The master drives the votes, mode and display select; the slave returns status and results.
interface vote_tally_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int TOT_W    = 10
) ();
  localparam int SEL_W = $clog2(NUM_CAND);

  logic                mode;
  logic [NUM_CAND-1:0] vote_valid;
  logic [SEL_W-1:0]    cand_sel;
  logic                vote_ack;
  logic                vote_reject;
  logic                busy;
  logic [CNT_W-1:0]    tally_out;
  logic [TOT_W-1:0]    total_out;

  modport master (
    output mode, vote_valid, cand_sel,
    input  vote_ack, vote_reject, busy, tally_out, total_out
  );

  modport slave (
    input  mode, vote_valid, cand_sel,
    output vote_ack, vote_reject, busy, tally_out, total_out
  );
endinterface

// File: rtl/vote_tally.sv
// Per-candidate saturating vote counters with single-vote qualification, a fixed
// hold-off window after each vote event, and a frozen result/display mode.
module vote_tally #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int TOT_W       = 10,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic        clock,
  input  logic        reset,
  vote_tally_if.slave bus
);
  localparam int SEL_W  = $clog2(NUM_CAND);
  localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);

  typedef enum logic [1:0] {IDLE, RECORD, HOLDOFF, RESULT} state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt [NUM_CAND];
  logic [TOT_W-1:0]    total;
  logic [SEL_W-1:0]    rec_idx, hot_idx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_load;
  logic                reject_d, reject_q;
  logic [CNT_W-1:0]    sel_tally;
  logic [CNT_W-1:0]    tally_q;
  logic [TOT_W-1:0]    total_q;

  // Index of the set bit; only meaningful when vote_valid is one-hot.
  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (bus.vote_valid[i]) hot_idx = SEL_W'(i);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    hold_load  = 1'b0;
    reject_d   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mode)
          next_state = RESULT;
        else if ($onehot(bus.vote_valid))
          next_state = RECORD;
        else if (|bus.vote_valid) begin
          next_state = HOLDOFF;
          hold_load  = 1'b1;
          reject_d   = 1'b1;
        end
      end
      RECORD: begin
        next_state = HOLDOFF;
        hold_load  = 1'b1;
      end
      HOLDOFF: if (hold_cnt == '0) next_state = IDLE;
      RESULT:  if (!bus.mode) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rec_idx  <= '0;
      hold_cnt <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= next_state;
      reject_q <= reject_d;
      if (state == IDLE) rec_idx <= hot_idx;
      if (hold_load)
        hold_cnt <= HOLD_W'(HOLDOFF_CYC - 1);
      else if (state == HOLDOFF && hold_cnt != '0)
        hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  // NOTE: the counter array is reset explicitly because reset is the only way to clear the tallies.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
      total <= '0;
    end else if (state == RECORD) begin
      if (cnt[rec_idx] != {CNT_W{1'b1}}) cnt[rec_idx] <= cnt[rec_idx] + CNT_W'(1);
      if (total != {TOT_W{1'b1}})        total        <= total + TOT_W'(1);
    end
  end

  // Out-of-range selections fall through to zero.
  always_comb begin
    sel_tally = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (bus.cand_sel == SEL_W'(i)) sel_tally = cnt[i];
  end

  // Display registers track the counters while RESULT is (or is about to be) active, else read 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tally_q <= '0;
      total_q <= '0;
    end else if (next_state == RESULT) begin
      tally_q <= sel_tally;
      total_q <= total;
    end else begin
      tally_q <= '0;
      total_q <= '0;
    end
  end

  assign bus.vote_ack    = (state == RECORD);
  assign bus.vote_reject = reject_q;
  assign bus.busy        = (state == RECORD) || (state == HOLDOFF);
  assign bus.tally_out   = tally_q;
  assign bus.total_out   = total_q;

endmodule

// File: tb/tb_vote_tally.sv
// Directed self-checking bench for vote_tally: voting, rejection, hold-off,
// result display, saturation and asynchronous reset.
module tb_vote_tally;
  localparam int NUM_CAND    = 4;
  localparam int CNT_W       = 8;
  localparam int TOT_W       = 10;
  localparam int HOLDOFF_CYC = 16;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  vote_tally_if #(.NUM_CAND(NUM_CAND), .CNT_W(CNT_W), .TOT_W(TOT_W)) bus ();

  vote_tally #(
    .NUM_CAND(NUM_CAND), .CNT_W(CNT_W), .TOT_W(TOT_W), .HOLDOFF_CYC(HOLDOFF_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // One-cycle vote pulse; returns with the DUT back in IDLE and the observed ack.
  task automatic vote(input logic [NUM_CAND-1:0] v, output logic ack);
    bus.vote_valid = v;
    tick();
    ack = bus.vote_ack;
    bus.vote_valid = '0;
    repeat (HOLDOFF_CYC + 1) tick();
  endtask

  // Enter RESULT showing candidate c; tally/total become valid one cycle later.
  task automatic show(input int c, input int exp_tally, input int exp_total, input string tag);
    bus.mode     = 1'b1;
    bus.cand_sel = c[1:0];
    tick();
    check({tag, "_tally"}, 32'(bus.tally_out), exp_tally);
    check({tag, "_total"}, 32'(bus.total_out), exp_total);
  endtask

  task automatic leave_result();
    bus.mode = 1'b0;
    tick();
  endtask

  initial begin
    logic ack;
    int   busy_cnt, ack_cnt, rej_cnt;

    bus.mode       = 1'b0;
    bus.vote_valid = '0;
    bus.cand_sel   = '0;
    reset          = 1'b0;
    repeat (3) tick();
    check("rst_ack",    32'(bus.vote_ack),    0);
    check("rst_reject", 32'(bus.vote_reject), 0);
    check("rst_busy",   32'(bus.busy),        0);
    check("rst_tally",  32'(bus.tally_out),   0);
    check("rst_total",  32'(bus.total_out),   0);
    reset = 1'b1;
    tick();

    // Single vote on candidate 1: ack next cycle, busy for 1+16 cycles.
    bus.vote_valid = 4'b0010;
    tick();
    check("a_ack", 32'(bus.vote_ack), 1);
    check("a_rej", 32'(bus.vote_reject), 0);
    bus.vote_valid = '0;
    busy_cnt = 0;
    ack_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      busy_cnt += int'(bus.busy);
      ack_cnt  += int'(bus.vote_ack);
      tick();
    end
    check("a_busy_cycles", 32'(busy_cnt), 17);
    check("a_ack_cycles",  32'(ack_cnt),  1);
    show(1, 1, 1, "a_c1");
    bus.cand_sel = 2'd0;
    tick();
    check("a_c0_tally", 32'(bus.tally_out), 0);
    check("a_busy_result", 32'(bus.busy), 0);
    bus.mode = 1'b0;
    tick();
    check("a_exit_tally", 32'(bus.tally_out), 0);
    check("a_exit_total", 32'(bus.total_out), 0);

    // Votes 0,0,3 from a clean reset.
    do_reset();
    vote(4'b0001, ack); check("b_ack0", 32'(ack), 1);
    vote(4'b0001, ack); check("b_ack1", 32'(ack), 1);
    vote(4'b1000, ack); check("b_ack2", 32'(ack), 1);
    show(0, 2, 3, "b_c0");
    bus.cand_sel = 2'd3; tick();
    check("b_c3_tally", 32'(bus.tally_out), 1);
    bus.cand_sel = 2'd1; tick();
    check("b_c1_tally", 32'(bus.tally_out), 0);
    leave_result();

    // Multi-hot vote is rejected, busy for exactly 16 cycles, nothing counted.
    do_reset();
    bus.vote_valid = 4'b0101;
    tick();
    bus.vote_valid = '0;
    check("c_reject", 32'(bus.vote_reject), 1);
    check("c_ack",    32'(bus.vote_ack),    0);
    busy_cnt = 0;
    ack_cnt  = 0;
    rej_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      busy_cnt += int'(bus.busy);
      ack_cnt  += int'(bus.vote_ack);
      rej_cnt  += int'(bus.vote_reject);
      tick();
    end
    check("c_busy_cycles", 32'(busy_cnt), 16);
    check("c_ack_cycles",  32'(ack_cnt),  0);
    check("c_rej_cycles",  32'(rej_cnt),  1);
    show(0, 0, 0, "c_c0");
    bus.cand_sel = 2'd2; tick();
    check("c_c2_tally", 32'(bus.tally_out), 0);
    leave_result();

    // Pulses inside hold-off are dropped; the first IDLE cycle accepts.
    do_reset();
    bus.vote_valid = 4'b0100;
    tick();                         // RECORD (ack cycle)
    bus.vote_valid = '0;
    repeat (5) tick();              // 5 cycles into HOLDOFF
    bus.vote_valid = 4'b0100;
    tick();
    bus.vote_valid = '0;
    check("d_mid_ack", 32'(bus.vote_ack), 0);
    check("d_mid_busy", 32'(bus.busy), 1);
    repeat (10) tick();             // last HOLDOFF cycle is next
    bus.vote_valid = 4'b0100;       // sampled on the final HOLDOFF edge: ignored
    tick();
    check("d_edge_ack",  32'(bus.vote_ack), 0);
    check("d_edge_busy", 32'(bus.busy),     0);
    tick();                         // sampled in IDLE: accepted
    bus.vote_valid = '0;
    check("d_accept_ack", 32'(bus.vote_ack), 1);
    repeat (HOLDOFF_CYC + 1) tick();
    show(2, 2, 2, "d_c2");
    leave_result();

    // Saturation: 256 votes on candidate 2, then 768 on candidate 1 (total saturates at 1023).
    do_reset();
    ack_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      vote(4'b0100, ack);
      ack_cnt += int'(ack);
    end
    check("e_acks_c2", 32'(ack_cnt), 256);
    show(2, 255, 256, "e_c2");
    bus.cand_sel = 2'd0; tick();
    check("e_c0_tally", 32'(bus.tally_out), 0);
    leave_result();
    ack_cnt = 0;
    for (int i = 0; i < 768; i++) begin
      vote(4'b0010, ack);
      ack_cnt += int'(ack);
    end
    check("e_acks_c1", 32'(ack_cnt), 768);
    show(1, 255, 1023, "e_c1");
    bus.cand_sel = 2'd2; tick();
    check("e_c2_tally_after", 32'(bus.tally_out), 255);
    leave_result();

    // Asynchronous reset mid-HOLDOFF.
    do_reset();
    bus.vote_valid = 4'b0001;
    tick();
    bus.vote_valid = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("f_hold_busy", 32'(bus.busy), 0);
    tick();
    reset = 1'b1;
    tick();
    show(0, 0, 0, "f_hold_c0");
    leave_result();

    // Asynchronous reset in RESULT clears the display immediately.
    vote(4'b1000, ack);
    show(3, 1, 1, "f_res_pre");
    #2;
    reset = 1'b0;
    #1;
    check("f_res_tally", 32'(bus.tally_out), 0);
    check("f_res_total", 32'(bus.total_out), 0);
    bus.mode = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("f_res_busy", 32'(bus.busy), 0);

    // Asynchronous reset mid-RECORD leaves no increment behind.
    bus.vote_valid = 4'b0001;
    tick();
    bus.vote_valid = '0;
    reset = 1'b0;
    #1;
    check("f_rec_ack", 32'(bus.vote_ack), 0);
    tick();
    reset = 1'b1;
    tick();
    show(0, 0, 0, "f_rec_c0");
    leave_result();

    // mode=1 with a simultaneous vote: RESULT wins, vote ignored.
    bus.mode       = 1'b1;
    bus.vote_valid = 4'b0010;
    bus.cand_sel   = 2'd1;
    tick();
    bus.vote_valid = '0;
    check("g_ack",   32'(bus.vote_ack),  0);
    check("g_busy",  32'(bus.busy),      0);
    check("g_tally", 32'(bus.tally_out), 0);
    check("g_total", 32'(bus.total_out), 0);
    leave_result();
    vote(4'b0010, ack);
    check("g_after_ack", 32'(ack), 1);
    show(1, 1, 1, "g_c1");
    leave_result();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Downstream consumer of the per-candidate button debounce/qualify stages: takes their one-cycle valid-vote pulses, records at most one vote per event into per-candidate saturating counters, then enforces a hold-off window.
- In result mode it freezes voting and presents the selected candidate's tally and the grand total for the display stage.

Parameters:
- NUM_CAND, 4, number of candidates; one vote-pulse input bit per candidate; must be 2..16.
- CNT_W, 8, width of each per-candidate counter and of tally_out.
- TOT_W, 10, width of the total-vote counter.
- HOLDOFF_CYC, 16, cycles spent in HOLDOFF after every accepted or rejected vote; must be ≥1.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets, 1 runs; deassertion is synchronised externally.
- mode  in  1  0 = voting, 1 = result display.
- vote_valid  in  NUM_CAND  one-cycle pulses from the per-candidate qualify stages; bit i = candidate i.
- cand_sel  in  $clog2(NUM_CAND)  candidate index for display; values ≥ NUM_CAND select nothing.
- vote_ack  out  1  one-cycle pulse: vote recorded.
- vote_reject  out  1  one-cycle pulse: multi-hot vote discarded.
- busy  out  1  high in RECORD and HOLDOFF.
- tally_out  out  CNT_W  registered count of candidate cand_sel (RESULT only, else 0).
- total_out  out  TOT_W  registered total accepted votes (RESULT only, else 0).

Behaviour:
- Reset (reset=0, async): all counters 0, state IDLE, every output 0.
- States: IDLE, RECORD, HOLDOFF, RESULT.
- IDLE transitions, priority in this order:
  - mode=1 → RESULT; vote_valid is ignored that cycle.
  - Exactly one vote_valid bit set → latch its index, go to RECORD.
  - More than one bit set → vote_reject=1 the next cycle, no count change, go to HOLDOFF.
  - Otherwise stay in IDLE.
- RECORD (exactly 1 cycle):
  - Increment count[idx] and total, each saturating at its all-ones value.
  - vote_ack=1 during this cycle; the ack is emitted even when saturated.
  - Load the hold-off counter with HOLDOFF_CYC-1, go to HOLDOFF.
- HOLDOFF:
  - vote_valid is ignored entirely; votes are not queued.
  - Decrement the hold-off counter each cycle; at 0 go to IDLE. Total time in HOLDOFF is exactly HOLDOFF_CYC cycles.
  - mode is not sampled here. A mode=1 request takes effect on the first IDLE cycle after hold-off.
- RESULT:
  - tally_out <= count[cand_sel] and total_out <= total each cycle: 1-cycle latency from cand_sel.
  - Out-of-range cand_sel → tally_out=0.
  - Counters are frozen; vote_valid is ignored.
  - mode=0 → IDLE next cycle, with tally_out/total_out cleared in that same cycle.
- Vote latency: vote_valid pulse in IDLE at cycle N → vote_ack and count update visible at cycle N+1. The next vote is accepted no earlier than cycle N+2+HOLDOFF_CYC.
- Multi-hot reject latency: vote_valid multi-hot at cycle N → vote_reject at cycle N+1 (first HOLDOFF cycle). The next vote is accepted no earlier than cycle N+1+HOLDOFF_CYC.
- vote_ack and vote_reject are never high together; busy = (state==RECORD || state==HOLDOFF).
- Saturation: a counter at max stays at max; the other counters still update normally.
- Reset asserted in any state: immediate return to reset values, including mid-RECORD, so no partial increment survives.
- Counters are not cleared by mode changes; only reset clears them.

Test Plan:
- Reset, then single pulse vote_valid=4'b0010 → vote_ack next cycle; busy for 1+16 cycles; then mode=1, cand_sel=1 → tally_out=1, total_out=1 one cycle later.
- Pulses on candidates 0,0,3 spaced 20 cycles → RESULT shows cand 0=2, cand 3=1, cand 1=0, total=3.
- vote_valid=4'b0101 in IDLE → vote_reject 1 cycle, no ack, all counts 0, busy for 16 cycles.
- Pulse during HOLDOFF (5 cycles after ack) → no ack, count unchanged; a pulse at cycle 17 after ack is accepted.
- CNT_W=8: 256 votes on candidate 2 → tally 255, total 256, vote_ack on every vote.
- Drop reset mid-HOLDOFF and in RESULT → outputs 0 immediately, counts 0, state IDLE after release; mode=1 with a simultaneous vote → RESULT entered, vote ignored.
